ready_event_collector: RTL and testbench

- Parametrised multi-channel ready/finish collector for the scheduler event-ordering test benches.
- Each channel carries a set request. Each channel has a sticky ready flag with 0->1 edge detection, so a repeated set on a ready channel is a no-op.
- Completion is evaluated in either all-channel or any-channel mode. An optional watchdog catches runs that never complete.
- Sits between stimulus generators and the bench's finish/report logic. Its single finish pulse replaces ad-hoc posedge-ready blocks.

---
 rtl/ready_event_collector_if.sv | 31 +++
 rtl/ready_event_collector.sv | 127 ++++++++++++
 tb/tb_ready_event_collector.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ready_event_collector_if.sv
// Handshake bundle for ready_event_collector.
// Carries the start/clr/set_i commands and every collector output.
//   master : drives start, clr, set_i; observes the rest
//   slave  : the collector itself
interface ready_event_collector_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8
);
    logic              start;
    logic              clr;
    logic [NUM_CH-1:0] set_i;
    logic [NUM_CH-1:0] ready_o;
    logic [NUM_CH-1:0] rise_o;
    logic              done_o;
    logic              finished_o;
    logic              timeout_o;
    logic [CNT_W-1:0]  edge_cnt_o;
    logic [1:0]        state_o;

    modport master (
        output start, clr, set_i,
        input  ready_o, rise_o, done_o, finished_o,
        input  timeout_o, edge_cnt_o, state_o
    );

    modport slave (
        input  start, clr, set_i,
        output ready_o, rise_o, done_o, finished_o,
        output timeout_o, edge_cnt_o, state_o
    );
endinterface

// File: rtl/ready_event_collector.sv
// Multi-channel sticky ready collector with all/any completion and watchdog.
// Ports: clk, rst (async, active high), bus (slave side of the _if bundle:
//   start, clr, set_i in; ready_o, rise_o, done_o, finished_o,
//   timeout_o, edge_cnt_o, state_o out).
module ready_event_collector #(
    parameter int NUM_CH   = 4,
    parameter int MODE_ANY = 0,
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 0,
    parameter int TO_W     = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    ready_event_collector_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMED     = 2'd1,
        DONE      = 2'd2,
        TIMED_OUT = 2'd3
    } state_t;

    localparam int SW = CNT_W + 6;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] ready_q, ready_d;
    logic [NUM_CH-1:0] rise_q, rise_d;
    logic              done_q, done_d;
    logic              fin_q, fin_d;
    logic              to_q, to_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TO_W-1:0]   wd_q, wd_d;

    logic [NUM_CH-1:0] nxt;
    logic [NUM_CH-1:0] rise_w;
    logic [5:0]        pop;
    logic [SW-1:0]     sum;
    logic              complete;
    logic              expire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= '0;
            rise_q  <= '0;
            done_q  <= 1'b0;
            fin_q   <= 1'b0;
            to_q    <= 1'b0;
            cnt_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rise_q  <= rise_d;
            done_q  <= done_d;
            fin_q   <= fin_d;
            to_q    <= to_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        rise_d  = '0;
        done_d  = 1'b0;
        fin_d   = fin_q;
        to_d    = to_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;

        nxt    = ready_q | bus.set_i;
        rise_w = bus.set_i & ~ready_q;
        pop    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop = pop + 6'(rise_w[i]);
        end
        sum = SW'(cnt_q) + SW'(pop);

        complete = (MODE_ANY != 0) ? (|nxt) : (&nxt);
        // wd_q counts ARMED cycles already seen, so TIMEOUT-1 marks the last one
        expire   = (TIMEOUT != 0) && (wd_q == TO_W'(TIMEOUT - 1));

        if (bus.clr) begin
            state_d = IDLE;
            ready_d = '0;
            fin_d   = 1'b0;
            to_d    = 1'b0;
            cnt_d   = '0;
            wd_d    = '0;
        end else if (bus.start) begin
            state_d = ARMED;
            ready_d = '0;
            fin_d   = 1'b0;
            to_d    = 1'b0;
            cnt_d   = '0;
            wd_d    = '0;
        end else if (state_q == ARMED) begin
            ready_d = nxt;
            rise_d  = rise_w;
            wd_d    = wd_q + TO_W'(1);
            if (sum > SW'({CNT_W{1'b1}})) begin
                cnt_d = {CNT_W{1'b1}};
            end else begin
                cnt_d = sum[CNT_W-1:0];
            end
            // completion outranks a watchdog expiring in the same cycle
            if (complete) begin
                state_d = DONE;
                done_d  = 1'b1;
                fin_d   = 1'b1;
            end else if (expire) begin
                state_d = TIMED_OUT;
                to_d    = 1'b1;
            end
        end
    end

    assign bus.ready_o    = ready_q;
    assign bus.rise_o     = rise_q;
    assign bus.done_o     = done_q;
    assign bus.finished_o = fin_q;
    assign bus.timeout_o  = to_q;
    assign bus.edge_cnt_o = cnt_q;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_ready_event_collector.sv
// Bench for ready_event_collector: two instances (all-mode with watchdog,
// any-mode with a 2-bit counter) share one stimulus stream.
module tb_ready_event_collector;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       clr;
    logic [3:0] set;
    int nchk = 0;
    int nerr = 0;

    ready_event_collector_if #(.NUM_CH(4), .CNT_W(8)) ifa ();
    ready_event_collector_if #(.NUM_CH(4), .CNT_W(2)) ifb ();

    assign ifa.start = start;
    assign ifa.clr   = clr;
    assign ifa.set_i = set;
    assign ifb.start = start;
    assign ifb.clr   = clr;
    assign ifb.set_i = set;

    ready_event_collector #(
        .NUM_CH(4), .MODE_ANY(0), .CNT_W(8), .TIMEOUT(10), .TO_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave)
    );

    ready_event_collector #(
        .NUM_CH(4), .MODE_ANY(1), .CNT_W(2), .TIMEOUT(0), .TO_W(16)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave)
    );

    always #5 clk = ~clk;

    // behavioural model: state 0 idle, 1 armed, 2 done, 3 timed out
    int         any_m[2] = '{0, 1};
    int         cmax[2]  = '{255, 3};
    int         tout[2]  = '{10, 0};
    logic [3:0] m_rdy[2];
    logic [3:0] m_rise[2];
    bit         m_done[2];
    bit         m_fin[2];
    bit         m_to[2];
    int         m_cnt[2];
    int         m_st[2];
    int         m_age[2];

    task automatic model_clear(int k);
        m_rdy[k]  = '0;
        m_rise[k] = '0;
        m_done[k] = 1'b0;
        m_fin[k]  = 1'b0;
        m_to[k]   = 1'b0;
        m_cnt[k]  = 0;
        m_age[k]  = 0;
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            logic [3:0] fresh;
            bool_done_reset(k);
            if (rst) begin
                model_clear(k);
                m_st[k] = 0;
            end else if (clr || start) begin
                model_clear(k);
                m_st[k] = clr ? 0 : 1;
            end else if (m_st[k] == 1) begin
                fresh     = set & ~m_rdy[k];
                m_rdy[k]  = m_rdy[k] | set;
                m_rise[k] = fresh;
                m_cnt[k]  = m_cnt[k] + $countones(fresh);
                m_age[k]  = m_age[k] + 1;
                if (any_m[k] != 0 ? (m_rdy[k] != 0) : (m_rdy[k] == 4'hF)) begin
                    m_st[k]   = 2;
                    m_done[k] = 1'b1;
                    m_fin[k]  = 1'b1;
                end else if (tout[k] != 0 && m_age[k] == tout[k]) begin
                    m_st[k] = 3;
                    m_to[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic bool_done_reset(int k);
        m_rise[k] = '0;
        m_done[k] = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            model_clear(k);
            m_st[k] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cmp(int k, logic [3:0] r, logic [3:0] rs, logic d,
                       logic f, logic t, logic [7:0] c, logic [1:0] s);
        string p = (k != 0) ? "b" : "a";
        int    cm = (m_cnt[k] > cmax[k]) ? cmax[k] : m_cnt[k];
        chk({p, ".ready"}, {4'b0, r}, {4'b0, m_rdy[k]});
        chk({p, ".rise"}, {4'b0, rs}, {4'b0, m_rise[k]});
        chk({p, ".done"}, {7'b0, d}, {7'b0, m_done[k]});
        chk({p, ".fin"}, {7'b0, f}, {7'b0, m_fin[k]});
        chk({p, ".tmo"}, {7'b0, t}, {7'b0, m_to[k]});
        chk({p, ".cnt"}, c, 8'(cm));
        chk({p, ".state"}, {6'b0, s}, 8'(m_st[k]));
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            cmp(0, ifa.ready_o, ifa.rise_o, ifa.done_o, ifa.finished_o,
                ifa.timeout_o, ifa.edge_cnt_o, ifa.state_o);
            cmp(1, ifb.ready_o, ifb.rise_o, ifb.done_o, ifb.finished_o,
                ifb.timeout_o, {6'b0, ifb.edge_cnt_o}, ifb.state_o);
        end
    end

    // one sampled clock edge per call; returns just after the next negedge
    task automatic cyc(logic s, logic c, logic [3:0] v);
        start = s;
        clr   = c;
        set   = v;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench time limit reached");
        $fatal(1, "bench hung");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        clr   = 1'b0;
        set   = 4'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.state", {6'b0, ifa.state_o}, 8'd0);
        chk("rst.ready", {4'b0, ifa.ready_o}, 8'h0);
        rst = 1'b0;

        // sequential one-hot sets
        cyc(1, 0, 4'hF);
        chk("arm.state", {6'b0, ifa.state_o}, 8'd1);
        chk("arm.ready", {4'b0, ifa.ready_o}, 8'h0);
        cyc(0, 0, 4'h1);
        chk("seq.rise0", {4'b0, ifa.rise_o}, 8'h1);
        chk("any.done", {7'b0, ifb.done_o}, 8'd1);
        cyc(0, 0, 4'h2);
        chk("seq.rise1", {4'b0, ifa.rise_o}, 8'h2);
        cyc(0, 0, 4'h4);
        cyc(0, 0, 4'h8);
        chk("seq.rise3", {4'b0, ifa.rise_o}, 8'h8);
        chk("seq.done", {7'b0, ifa.done_o}, 8'd1);
        chk("seq.ready", {4'b0, ifa.ready_o}, 8'hF);
        chk("seq.cnt", ifa.edge_cnt_o, 8'd4);
        chk("seq.state", {6'b0, ifa.state_o}, 8'd2);
        cyc(0, 0, 4'h0);
        chk("seq.done1cy", {7'b0, ifa.done_o}, 8'd0);

        // idempotent set
        cyc(1, 0, 4'h0);
        repeat (5) cyc(0, 0, 4'h1);
        chk("idem.cnt", ifa.edge_cnt_o, 8'd1);
        chk("idem.rise", {4'b0, ifa.rise_o}, 8'h0);
        chk("idem.state", {6'b0, ifa.state_o}, 8'd1);
        cyc(0, 0, 4'hE);
        chk("idem.rise2", {4'b0, ifa.rise_o}, 8'hE);
        chk("idem.done", {7'b0, ifa.done_o}, 8'd1);
        chk("idem.cnt2", ifa.edge_cnt_o, 8'd4);

        // any mode
        cyc(1, 0, 4'h0);
        cyc(0, 0, 4'h4);
        chk("any.ready", {4'b0, ifb.ready_o}, 8'h4);
        chk("any.done2", {7'b0, ifb.done_o}, 8'd1);
        chk("any.fin", {7'b0, ifb.finished_o}, 8'd1);
        cyc(0, 0, 4'hF);
        chk("any.frozen", {4'b0, ifb.ready_o}, 8'h4);
        chk("any.norise", {4'b0, ifb.rise_o}, 8'h0);

        // watchdog expiry
        cyc(1, 0, 4'h0);
        repeat (9) cyc(0, 0, 4'h0);
        chk("wd.pre", {6'b0, ifa.state_o}, 8'd1);
        cyc(0, 0, 4'h0);
        chk("wd.state", {6'b0, ifa.state_o}, 8'd3);
        chk("wd.tmo", {7'b0, ifa.timeout_o}, 8'd1);
        chk("wd.done", {7'b0, ifa.done_o}, 8'd0);
        chk("wd.off", {6'b0, ifb.state_o}, 8'd1);

        // completion in the expiry cycle
        cyc(1, 0, 4'h0);
        repeat (9) cyc(0, 0, 4'h0);
        cyc(0, 0, 4'hF);
        chk("wdx.done", {7'b0, ifa.done_o}, 8'd1);
        chk("wdx.tmo", {7'b0, ifa.timeout_o}, 8'd0);
        chk("wdx.state", {6'b0, ifa.state_o}, 8'd2);

        // clr beats start
        cyc(1, 1, 4'h0);
        chk("pri.state", {6'b0, ifa.state_o}, 8'd0);
        chk("pri.fin", {7'b0, ifa.finished_o}, 8'd0);
        chk("pri.ready", {4'b0, ifa.ready_o}, 8'h0);

        // re-arm from DONE, then saturation on b
        cyc(1, 0, 4'h0);
        cyc(0, 0, 4'hF);
        chk("sat.cnt", {6'b0, ifb.edge_cnt_o}, 8'd3);
        chk("sat.done", {7'b0, ifb.done_o}, 8'd1);
        cyc(1, 0, 4'h0);
        chk("rearm.state", {6'b0, ifa.state_o}, 8'd1);
        chk("rearm.ready", {4'b0, ifa.ready_o}, 8'h0);
        chk("rearm.cnt", ifa.edge_cnt_o, 8'd0);

        // asynchronous reset mid-ARMED
        cyc(0, 0, 4'h3);
        chk("mid.ready", {4'b0, ifa.ready_o}, 8'h3);
        set = 4'hC;
        #2;
        rst = 1'b1;
        #1;
        chk("arst.ready", {4'b0, ifa.ready_o}, 8'h0);
        chk("arst.state", {6'b0, ifa.state_o}, 8'd0);
        chk("arst.cnt", ifa.edge_cnt_o, 8'd0);
        @(negedge clk);
        #1;
        chk("arst.done", {7'b0, ifa.done_o}, 8'd0);
        rst = 1'b0;
        cyc(1, 0, 4'h0);
        cyc(0, 0, 4'hF);
        chk("post.done", {7'b0, ifa.done_o}, 8'd1);
        cyc(0, 1, 4'h0);
        chk("clr.state", {6'b0, ifa.state_o}, 8'd0);
        chk("clr.fin", {7'b0, ifa.finished_o}, 8'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
